// File: rtl/fp_mul_arbiter.sv
// Purpose : round-robin arbiter sharing one combinational FP multiplier among NUM_REQ requesters.
// Latency : accept edge -> out_valid after 2 edges (EXEC, RESP); one op in flight, 1 op / 3 cycles max.
// Backpressure: result held stable in RESP until out_ready; in_ready is 0 outside IDLE.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    per-requester handshake (in_ready one-hot or zero)
//   in_x/in_y            packed operands, requester i owns [i*BITS +: BITS]
//   out_valid/out_ready  result handshake
//   out_data/out_id      product and the index of the requester that issued it
//   busy                 FSM is not IDLE

// Combinational IEEE-style multiplier: round-to-nearest-even, subnormal inputs
// and results flush to signed zero, any NaN result is the canonical quiet NaN.
// Ports: x_i, y_i operands; product_o result.
module fpMultiplier #(
  parameter int BITS          = 32,
  parameter int MANTISSA_BITS = 23,
  parameter int EXPONENT_BITS = 8
) (
  input  logic [BITS-1:0] x_i,
  input  logic [BITS-1:0] y_i,
  output logic [BITS-1:0] product_o
);
  localparam int M = MANTISSA_BITS;
  localparam int E = EXPONENT_BITS;
  localparam logic signed [E+2:0] BIAS_S = (E+3)'((1 << (E-1)) - 1);
  localparam logic signed [E+2:0] EMAX_S = (E+3)'((1 << E) - 1);

  logic           sx, sy, sr;
  logic [E-1:0]   ex, ey;
  logic [M-1:0]   fx, fy;
  logic           x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  logic [2*M+1:0] mx, my, prod;

  logic           norm, guard, sticky, round_up, carry;
  logic [M:0]     mant;
  logic [M+1:0]   mant_r;
  logic [M-1:0]   frac;
  logic signed [E+2:0] exp_f;

  assign sx = x_i[BITS-1];
  assign sy = y_i[BITS-1];
  assign sr = sx ^ sy;
  assign ex = x_i[BITS-2 -: E];
  assign ey = y_i[BITS-2 -: E];
  assign fx = x_i[M-1:0];
  assign fy = y_i[M-1:0];

  // A zero exponent field covers both true zero and subnormals (flushed).
  assign x_zero = (ex == '0);
  assign y_zero = (ey == '0);
  assign x_inf  = (ex == '1) && (fx == '0);
  assign y_inf  = (ey == '1) && (fy == '0);
  assign x_nan  = (ex == '1) && (fx != '0);
  assign y_nan  = (ey == '1) && (fy != '0);

  assign mx   = {{(M+1){1'b0}}, 1'b1, fx};
  assign my   = {{(M+1){1'b0}}, 1'b1, fy};
  assign prod = mx * my;

  always_comb begin
    // Product of two [1,2) significands lies in [1,4); top bit selects the shift.
    norm = prod[2*M+1];
    if (norm) begin
      mant   = prod[2*M+1 -: M+1];
      guard  = prod[M];
      sticky = |prod[M-1:0];
    end else begin
      mant   = prod[2*M -: M+1];
      guard  = prod[M-1];
      sticky = |prod[M-2:0];
    end
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {{(M+1){1'b0}}, round_up};
    // Rounding carry-out leaves 10...0, so the fraction below the new hidden bit is zero.
    carry    = mant_r[M+1];
    frac     = carry ? mant_r[M:1] : mant_r[M-1:0];
    exp_f    = $signed({3'b000, ex}) + $signed({3'b000, ey}) - BIAS_S
             + $signed({{(E+2){1'b0}}, norm}) + $signed({{(E+2){1'b0}}, carry});

    product_o = '0;
    if (x_nan || y_nan || (x_inf && y_zero) || (x_zero && y_inf)) begin
      product_o = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    end else if (x_inf || y_inf) begin
      product_o = {sr, {E{1'b1}}, {M{1'b0}}};
    end else if (x_zero || y_zero) begin
      product_o = {sr, {(E+M){1'b0}}};
    end else if (exp_f >= EMAX_S) begin
      product_o = {sr, {E{1'b1}}, {M{1'b0}}};
    end else if (exp_f <= 0) begin
      product_o = {sr, {(E+M){1'b0}}};
    end else begin
      product_o = {sr, exp_f[E-1:0], frac};
    end
  end
endmodule

module fp_mul_arbiter #(
  parameter int BITS          = 32,
  parameter int MANTISSA_BITS = 23,
  parameter int EXPONENT_BITS = 8,
  parameter int NUM_REQ       = 4,
  localparam int ID_BITS      = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      in_valid,
  output logic [NUM_REQ-1:0]      in_ready,
  input  logic [NUM_REQ*BITS-1:0] in_x,
  input  logic [NUM_REQ*BITS-1:0] in_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BITS-1:0]         out_data,
  output logic [ID_BITS-1:0]      out_id,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [ID_BITS-1:0] RR_INIT = ID_BITS'(NUM_REQ - 1);

  state_t              state_q, state_d;
  logic [ID_BITS-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_BITS-1:0]  id_q, id_d;
  logic [BITS-1:0]     x_q, x_d, y_q, y_d;
  logic [BITS-1:0]     out_data_q, out_data_d;
  logic [ID_BITS-1:0]  out_id_q, out_id_d;
  logic                out_valid_q, out_valid_d;

  logic                grant_vld;
  logic [ID_BITS-1:0]  grant_idx;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [BITS-1:0]     x_sel, y_sel;
  logic [BITS-1:0]     product;

  fpMultiplier #(
    .BITS          (BITS),
    .MANTISSA_BITS (MANTISSA_BITS),
    .EXPONENT_BITS (EXPONENT_BITS)
  ) u_mul (
    .x_i       (x_q),
    .y_i       (y_q),
    .product_o (product)
  );

  // Round-robin pick: the valid requester with the smallest circular distance
  // past rr_ptr wins (distance 0 is rr_ptr+1, rr_ptr itself is searched last).
  always_comb begin
    int best_d;
    int d;
    best_d    = NUM_REQ;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + NUM_REQ - int'(rr_ptr_q) - 1) % NUM_REQ;
      if (in_valid[i] && (d < best_d)) begin
        best_d    = d;
        grant_vld = 1'b1;
        grant_idx = ID_BITS'(i);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    x_sel    = '0;
    y_sel    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_BITS'(i)) begin
        grant_oh[i] = grant_vld;
        x_sel       = in_x[i*BITS +: BITS];
        y_sel       = in_y[i*BITS +: BITS];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    x_d         = x_q;
    y_d         = y_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_valid_d = out_valid_q;
    in_ready    = '0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          in_ready = grant_oh;
          x_d      = x_sel;
          y_d      = y_sel;
          id_d     = grant_idx;
          rr_ptr_d = grant_idx;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        out_data_d  = product;
        out_id_d    = id_q;
        out_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        // No same-cycle re-accept: IDLE is re-entered before the next grant.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= RR_INIT;
      id_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      x_q         <= x_d;
      y_q         <= y_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q != IDLE);
endmodule
